top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 Parameter DSTACK_DEPTH, default 16, data stack entries (circular).
REQ-002 Parameter RSTACK_DEPTH, default 16, return stack entries (circular).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 nCS  input  1  SPI chip select, active low; async to clk.
REQ-006 SCK  input  1  SPI clock, mode 0; async to clk.
REQ-007 MOSI  input  1  SPI data in, MSB first.
REQ-008 pins  inout  16  GPIO; pins[i] driven with OUT[i] when OE[i]=1, else high-Z.

Function
REQ-009 Stack CPU: one instruction per clk cycle; iram 256x16 with combinational fetch at iram[PC[7:0]]; PC 13 bits, resets to 0.
REQ-010 Decode by instr[15:13]: 1xx literal (push instr[14:0] zero-extended); 010 jump to instr[12:0]; 011 0branch (pop T, jump to instr[12:0] if T==0, else PC+1); 001 call (push PC+1 to return stack, jump); 000 ALU.
REQ-011 ALU op instr[11:8] (N=second): 0 N+T; 1 N-T; 2 N&T; 3 N|T; 4 N^T; 5 ~T; 6 (N==T)?FFFF:0; 7 signed (N<T)?FFFF:0; 8 T (DUP with push); 9 N (DROP with pop); A SWAP (T<=N, N<=T); B N (OVER with push); C mem[T] (@); D !+ (write N to mem[T], result T+1); E T>>1 logical; F T<<1.
REQ-012 ALU instr[7:6] = data-stack delta: 00 0, 01 +1, 11 -1, 10 -2; result goes to new T; on push old T becomes N.
REQ-013 ALU instr[5]=1: return (PC<=R, pop return stack); else PC+1. instr[4:0] ignored.
REQ-014 Data map: 0x000-0x0FF data RAM 256x16 (separate from iram, combinational read); 0x100 OUT reg; 0x101 OE reg; 0x102 read-only pins input (2-FF synchronised); other addresses write-ignored, read 0.
REQ-015 OUT/OE reads return register values; writes take effect the cycle after the !+ executes.
REQ-016 All arithmetic 16-bit, wrap-around, no flags; stack pointers wrap silently on over/underflow.
REQ-017 SPI loader: nCS, SCK, MOSI each 2-FF synchronised; SCK rising edge detected in clk domain; SCK ≤ clk/4.
REQ-018 nCS falling: word counter and bit counter cleared; CPU held (PC=0, stack pointers 0, no fetch effects) while nCS low.
REQ-019 Each 16 sampled bits write iram[word counter]; counter increments, wraps at 256; partial word at nCS rise discarded.
REQ-020 nCS rising: CPU released and executes from PC=0; OUT/OE/data RAM retain values.

Reset
REQ-021 reset low: PC=0, both stack pointers 0, T=0, OUT=0, OE=0 (pins all Z), SPI counters 0, synchronisers cleared; iram and data RAM not cleared.
REQ-022 Reset mid-operation aborts instruction or SPI word immediately; execution restarts at 0 one cycle after reset deasserts.

Structure
REQ-023 Shared package: opcode field positions, ALU op codes, I/O addresses 0x100/0x101/0x102.
REQ-024 One sub-module, forth_core, instantiated as cpu_top, owning the hierarchically accessible array iram[0:255] of 16-bit words; SPI loader, I/O registers and tri-states live in top.

Verification
REQ-025 Preload iram: 8003,8101,0dc0,8002,8020,0840,600a,8001,01c0,4005,09c0,8003,04c0,0840,8100,0dc0,09c0,4004 -> OE=0x0003 after 3rd instruction; pins[15:2]=Z; pins[1:0]=01 after 173rd instruction, then 10, 01, ... every 171 cycles.
REQ-026 Literals 5,3 then ALU ops 0,1,4,6,7 -> T=8, 2, 6, 0000, 0000 (plus -1,0xFFFF cases for 6 and 7).
REQ-027 SPI shift 0x8042,0x4001 with nCS low -> iram[0]=8042, iram[1]=4001; CPU idle while nCS low, runs from 0 after nCS rises.
REQ-028 17 consecutive DUPs -> stack pointer wraps, no hang; 0branch with T=1 falls through, T=0 jumps.
REQ-029 Assert reset low mid-loop with OE=3 -> pins all Z, PC=0 asynchronously; restart re-executes program identically.

Source files
------------

// File: rtl/forth_pkg.sv
// Shared definitions for the stack CPU: instruction field positions,
// instruction classes, ALU operation codes and the I/O register map.
package forth_pkg;
  localparam int PC_W       = 13;
  localparam int OP_LIT_BIT = 15;
  localparam int OP_CLS_HI  = 15;
  localparam int OP_CLS_LO  = 13;
  localparam int OP_ALU_HI  = 11;
  localparam int OP_ALU_LO  = 8;
  localparam int OP_DD_HI   = 7;
  localparam int OP_DD_LO   = 6;
  localparam int OP_RET_BIT = 5;

  localparam logic [2:0] CLS_ALU     = 3'b000;
  localparam logic [2:0] CLS_CALL    = 3'b001;
  localparam logic [2:0] CLS_JUMP    = 3'b010;
  localparam logic [2:0] CLS_ZBRANCH = 3'b011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0, ALU_SUB  = 4'h1, ALU_AND  = 4'h2, ALU_OR    = 4'h3,
    ALU_XOR   = 4'h4, ALU_INV  = 4'h5, ALU_EQ   = 4'h6, ALU_LT    = 4'h7,
    ALU_T     = 4'h8, ALU_N    = 4'h9, ALU_SWAP = 4'hA, ALU_OVER  = 4'hB,
    ALU_FETCH = 4'hC, ALU_STORE = 4'hD, ALU_SHR = 4'hE, ALU_SHL   = 4'hF
  } alu_op_e;

  localparam logic [15:0] ADDR_OUT  = 16'h0100;
  localparam logic [15:0] ADDR_OE   = 16'h0101;
  localparam logic [15:0] ADDR_PINS = 16'h0102;
endpackage

// File: rtl/forth_core.sv
// Single-cycle stack CPU: instruction RAM, data RAM, data and return stacks.
// Addresses 0x100 and above are forwarded to the I/O block in the top level.
module forth_core
  import forth_pkg::*;
#(
  parameter int DSTACK_DEPTH = 16,
  parameter int RSTACK_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        load_we,
  input  logic [7:0]  load_addr,
  input  logic [15:0] load_data,
  output logic [15:0] io_addr,
  output logic        io_we,
  output logic [15:0] io_wdata,
  input  logic [15:0] io_rdata
);
  localparam int DPW = $clog2(DSTACK_DEPTH);
  localparam int RPW = $clog2(RSTACK_DEPTH);

  logic [15:0]     iram   [0:255];
  logic [15:0]     dram   [0:255];
  logic [15:0]     dstack [0:DSTACK_DEPTH-1];
  logic [PC_W-1:0] rstack [0:RSTACK_DEPTH-1];

  logic [PC_W-1:0]    pc, pc_nxt, pc_inc, r, target;
  logic [DPW-1:0]     dsp, dsp_nxt;
  logic [RPW-1:0]     rsp, rsp_nxt;
  logic [15:0]        t, t_nxt, n, insn, alu;
  logic signed [15:0] n_s, t_s;
  logic               d_we, r_we, dram_we, is_io;
  alu_op_e            op;

  assign insn     = iram[pc[7:0]];
  assign n        = dstack[dsp];
  assign r        = rstack[rsp];
  assign n_s      = n;
  assign t_s      = t;
  assign op       = alu_op_e'(insn[OP_ALU_HI:OP_ALU_LO]);
  assign target   = insn[PC_W-1:0];
  assign pc_inc   = pc + PC_W'(1);
  assign is_io    = (t[15:8] != 8'h00);
  assign io_addr  = t;
  assign io_wdata = n;

  always_comb begin
    alu = t;
    case (op)
      ALU_ADD:   alu = n + t;
      ALU_SUB:   alu = n - t;
      ALU_AND:   alu = n & t;
      ALU_OR:    alu = n | t;
      ALU_XOR:   alu = n ^ t;
      ALU_INV:   alu = ~t;
      ALU_EQ:    alu = (n == t) ? 16'hFFFF : 16'h0000;
      ALU_LT:    alu = (n_s < t_s) ? 16'hFFFF : 16'h0000;
      ALU_T:     alu = t;
      ALU_N:     alu = n;
      ALU_SWAP:  alu = n;
      ALU_OVER:  alu = n;
      ALU_FETCH: alu = is_io ? io_rdata : dram[t[7:0]];
      ALU_STORE: alu = t + 16'd1;
      ALU_SHR:   alu = {1'b0, t[15:1]};
      ALU_SHL:   alu = {t[14:0], 1'b0};
      default:   alu = t;
    endcase
  end

  always_comb begin
    pc_nxt  = pc_inc;
    dsp_nxt = dsp;
    rsp_nxt = rsp;
    t_nxt   = t;
    d_we    = 1'b0;
    r_we    = 1'b0;
    dram_we = 1'b0;
    io_we   = 1'b0;
    if (insn[OP_LIT_BIT]) begin
      t_nxt   = {1'b0, insn[14:0]};
      dsp_nxt = dsp + DPW'(1);
      d_we    = 1'b1;
    end else begin
      case (insn[OP_CLS_HI:OP_CLS_LO])
        CLS_JUMP: pc_nxt = target;
        CLS_ZBRANCH: begin
          t_nxt   = n;
          dsp_nxt = dsp - DPW'(1);
          if (t == 16'h0000) pc_nxt = target;
        end
        CLS_CALL: begin
          rsp_nxt = rsp + RPW'(1);
          r_we    = 1'b1;
          pc_nxt  = target;
        end
        default: begin
          t_nxt = alu;
          case (insn[OP_DD_HI:OP_DD_LO])
            2'b01: begin
              dsp_nxt = dsp + DPW'(1);
              d_we    = 1'b1;
            end
            2'b11:   dsp_nxt = dsp - DPW'(1);
            2'b10:   dsp_nxt = dsp - DPW'(2);
            default: dsp_nxt = dsp;
          endcase
          // SWAP keeps depth but the old T must land in N
          if (op == ALU_SWAP) d_we = 1'b1;
          if (op == ALU_STORE) begin
            dram_we = ~is_io;
            io_we   = is_io;
          end
          if (insn[OP_RET_BIT]) begin
            pc_nxt  = r;
            rsp_nxt = rsp - RPW'(1);
          end
        end
      endcase
    end
    if (hold || !reset) begin
      d_we    = 1'b0;
      r_we    = 1'b0;
      dram_we = 1'b0;
      io_we   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (d_we)    dstack[dsp_nxt] <= t;
    if (r_we)    rstack[rsp_nxt] <= pc_inc;
    if (dram_we) dram[t[7:0]]    <= n;
    if (load_we) iram[load_addr] <= load_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc  <= '0;
      dsp <= '0;
      rsp <= '0;
      t   <= '0;
    end else if (hold) begin
      pc  <= '0;
      dsp <= '0;
      rsp <= '0;
    end else begin
      pc  <= pc_nxt;
      dsp <= dsp_nxt;
      rsp <= rsp_nxt;
      t   <= t_nxt;
    end
  end
endmodule

// File: rtl/top.sv
// Stack CPU system: SPI program loader, OUT/OE/pin I/O registers and the
// GPIO tri-state drivers around the forth_core instance.
module top
  import forth_pkg::*;
#(
  parameter int DSTACK_DEPTH = 16,
  parameter int RSTACK_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nCS,
  input  logic        SCK,
  input  logic        MOSI,
  inout  wire  [15:0] pins
);
  logic        cs_s1, cs_s2, cs_s3, sck_s1, sck_s2, sck_s3, mosi_s1, mosi_s2;
  logic        cs_fall, sck_rise, spi_bit, hold, load_we, io_we;
  logic [3:0]  bit_cnt;
  logic [7:0]  word_cnt;
  logic [14:0] shift;
  logic [15:0] pin_s1, pin_s2, out_reg, oe_reg, io_addr, io_wdata, io_rdata;

  assign cs_fall  = cs_s3 & ~cs_s2;
  assign sck_rise = sck_s2 & ~sck_s3;
  assign spi_bit  = ~cs_s2 & sck_rise & ~cs_fall;
  assign load_we  = spi_bit && (bit_cnt == 4'd15);
  assign hold     = ~cs_s2;

  // nCS synchroniser resets to the idle-high level so the CPU runs after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {cs_s1, cs_s2, cs_s3}    <= 3'b111;
      {sck_s1, sck_s2, sck_s3} <= 3'b000;
      {mosi_s1, mosi_s2}       <= 2'b00;
      pin_s1   <= '0;
      pin_s2   <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      {cs_s1, cs_s2, cs_s3}    <= {nCS, cs_s1, cs_s2};
      {sck_s1, sck_s2, sck_s3} <= {SCK, sck_s1, sck_s2};
      {mosi_s1, mosi_s2}       <= {MOSI, mosi_s1};
      pin_s1 <= pins;
      pin_s2 <= pin_s1;
      if (cs_fall) begin
        bit_cnt  <= '0;
        word_cnt <= '0;
      end else if (spi_bit) begin
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd15) word_cnt <= word_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (spi_bit) shift <= {shift[13:0], mosi_s2};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_reg <= '0;
      oe_reg  <= '0;
    end else if (io_we) begin
      if (io_addr == ADDR_OUT) out_reg <= io_wdata;
      if (io_addr == ADDR_OE)  oe_reg  <= io_wdata;
    end
  end

  always_comb begin
    io_rdata = 16'h0000;
    case (io_addr)
      ADDR_OUT:  io_rdata = out_reg;
      ADDR_OE:   io_rdata = oe_reg;
      ADDR_PINS: io_rdata = pin_s2;
      default:   io_rdata = 16'h0000;
    endcase
  end

  for (genvar i = 0; i < 16; i++) begin : g_pin
    assign pins[i] = oe_reg[i] ? out_reg[i] : 1'bz;
  end

  forth_core #(
    .DSTACK_DEPTH(DSTACK_DEPTH),
    .RSTACK_DEPTH(RSTACK_DEPTH)
  ) cpu_top (
    .clk       (clk),
    .reset     (reset),
    .hold      (hold),
    .load_we   (load_we),
    .load_addr (word_cnt),
    .load_data ({shift, mosi_s2}),
    .io_addr   (io_addr),
    .io_we     (io_we),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata)
  );
endmodule

// File: tb/tb_top.sv
// Scoreboard bench for the stack CPU system: blinker program, ALU ops,
// SPI loading, stack wrap / 0branch and asynchronous mid-run reset.
module tb_top;
  logic clk = 1'b0;
  logic reset, nCS, SCK, MOSI;
  wire [15:0] pins;

  int total = 0;
  int bad = 0;

  localparam int K_OE = 0, K_PINS = 1, K_T = 2, K_PC = 3, K_DSP = 4, K_OUT = 5;
  localparam int K_IRAM0 = 6, K_IRAM1 = 7, K_IRAM2 = 8;

  typedef struct { int cyc; int kind; logic [15:0] val; } exp_t;
  exp_t        sb[$];
  exp_t        e;
  logic [15:0] obs;
  logic [15:0] img[$];

  logic [15:0] blink [0:17] = '{
    16'h8003, 16'h8101, 16'h0dc0, 16'h8002, 16'h8020, 16'h0840, 16'h600a, 16'h8001, 16'h01c0,
    16'h4005, 16'h09c0, 16'h8003, 16'h04c0, 16'h0840, 16'h8100, 16'h0dc0, 16'h09c0, 16'h4004};

  // five instruction words, then the expected T after the fifth edge
  logic [15:0] alu_tab [0:17][0:5] = '{
    '{16'h8005, 16'h8003, 16'h00C0, 16'h0800, 16'h0800, 16'h0008},
    '{16'h8005, 16'h8003, 16'h01C0, 16'h0800, 16'h0800, 16'h0002},
    '{16'h8005, 16'h8003, 16'h02C0, 16'h0800, 16'h0800, 16'h0001},
    '{16'h8005, 16'h8003, 16'h03C0, 16'h0800, 16'h0800, 16'h0007},
    '{16'h8005, 16'h8003, 16'h04C0, 16'h0800, 16'h0800, 16'h0006},
    '{16'h8005, 16'h8003, 16'h06C0, 16'h0800, 16'h0800, 16'h0000},
    '{16'h8005, 16'h8003, 16'h07C0, 16'h0800, 16'h0800, 16'h0000},
    '{16'h8003, 16'h8003, 16'h06C0, 16'h0800, 16'h0800, 16'hFFFF},
    '{16'h8000, 16'h0500, 16'h8001, 16'h07C0, 16'h0800, 16'hFFFF},
    '{16'h8003, 16'h8005, 16'h07C0, 16'h0800, 16'h0800, 16'hFFFF},
    '{16'h8005, 16'h0500, 16'h0800, 16'h0800, 16'h0800, 16'hFFFA},
    '{16'h8006, 16'h0E00, 16'h0800, 16'h0800, 16'h0800, 16'h0003},
    '{16'h8006, 16'h0F00, 16'h0800, 16'h0800, 16'h0800, 16'h000C},
    '{16'h8005, 16'h8003, 16'h0A00, 16'h09C0, 16'h0800, 16'h0003},
    '{16'h8005, 16'h8003, 16'h0B40, 16'h01C0, 16'h0800, 16'hFFFE},
    '{16'h8077, 16'h8010, 16'h0DC0, 16'h8010, 16'h0C00, 16'h0077},
    '{16'h8005, 16'h8101, 16'h0DC0, 16'h8101, 16'h0C00, 16'h0005},
    '{16'h8005, 16'h2003, 16'h8009, 16'h0820, 16'h0800, 16'h0009}};

  top #(.DSTACK_DEPTH(16), .RSTACK_DEPTH(16)) dut (
    .clk  (clk),
    .reset(reset),
    .nCS  (nCS),
    .SCK  (SCK),
    .MOSI (MOSI),
    .pins (pins)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] observe(input int kind);
    case (kind)
      K_OE:    return dut.oe_reg;
      K_PINS:  return {14'b0, pins[1:0]};
      K_T:     return dut.cpu_top.t;
      K_PC:    return {3'b0, dut.cpu_top.pc};
      K_DSP:   return 16'(dut.cpu_top.dsp);
      K_OUT:   return dut.out_reg;
      K_IRAM0: return dut.cpu_top.iram[0];
      K_IRAM1: return dut.cpu_top.iram[1];
      K_IRAM2: return dut.cpu_top.iram[2];
      default: return 16'hxxxx;
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      K_OE: return "oe"; K_PINS: return "pins10"; K_T: return "T"; K_PC: return "pc";
      K_DSP: return "dsp"; K_OUT: return "out"; K_IRAM0: return "iram0";
      K_IRAM1: return "iram1"; K_IRAM2: return "iram2"; default: return "?";
    endcase
  endfunction

  task automatic expect_at(input int c, input int k, input logic [15:0] v);
    exp_t x;
    x.cyc = c; x.kind = k; x.val = v;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic load_img();
    logic [7:0] a;
    for (int i = 0; i < img.size(); i++) begin
      a = 8'(i);
      dut.cpu_top.iram[a] = img[i];
    end
  endtask

  task automatic start_cpu();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic shift_word(input logic [15:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      MOSI = w[15-i];
      repeat (4) @(negedge clk);
      SCK = 1'b1;
      repeat (4) @(negedge clk);
      SCK = 1'b0;
    end
  endtask

  task automatic test_reset();
    nCS = 1'b1; SCK = 1'b0; MOSI = 1'b0;
    do_reset();
    total++; if (dut.cpu_top.pc !== 13'd0) begin bad++; $display("FAIL reset_pc got=%h want=0", dut.cpu_top.pc); end
    total++; if (dut.cpu_top.t !== 16'd0) begin bad++; $display("FAIL reset_t got=%h want=0", dut.cpu_top.t); end
    total++; if (dut.cpu_top.dsp !== 4'd0) begin bad++; $display("FAIL reset_dsp got=%h want=0", dut.cpu_top.dsp); end
    total++; if (dut.cpu_top.rsp !== 4'd0) begin bad++; $display("FAIL reset_rsp got=%h want=0", dut.cpu_top.rsp); end
    total++; if (dut.oe_reg !== 16'd0) begin bad++; $display("FAIL reset_oe got=%h want=0", dut.oe_reg); end
    total++; if (dut.out_reg !== 16'd0) begin bad++; $display("FAIL reset_out got=%h want=0", dut.out_reg); end
  endtask

  task automatic test_program();
    do_reset();
    img.delete();
    foreach (blink[i]) img.push_back(blink[i]);
    load_img();
    sb.delete();
    expect_at(2, K_OE, 16'h0000);
    expect_at(3, K_OE, 16'h0003);
    expect_at(3, K_OUT, 16'h0000);
    expect_at(5, K_PC, 16'h0005);
    expect_at(172, K_PINS, 16'h0000);
    expect_at(173, K_PINS, 16'h0001);
    expect_at(343, K_PINS, 16'h0001);
    expect_at(344, K_PINS, 16'h0002);
    expect_at(514, K_PINS, 16'h0002);
    expect_at(515, K_PINS, 16'h0001);
    start_cpu();
    for (int c = 1; c <= 520; c++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); obs = observe(e.kind); total++;
        if (obs !== e.val) begin bad++; $display("FAIL prog_%s cyc=%0d got=%h want=%h", kname(e.kind), c, obs, e.val); end
      end
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL prog_pending got=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_alu();
    for (int r = 0; r < 18; r++) begin
      do_reset();
      img.delete();
      for (int k = 0; k < 5; k++) img.push_back(alu_tab[r][k]);
      img.push_back(16'h4005);
      load_img();
      sb.delete();
      expect_at(5, K_T, alu_tab[r][5]);
      start_cpu();
      for (int c = 1; c <= 5; c++) begin
        @(posedge clk); #1;
        while (sb.size() > 0 && sb[0].cyc == c) begin
          e = sb.pop_front(); obs = observe(e.kind); total++;
          if (obs !== e.val) begin bad++; $display("FAIL alu_row%0d got=%h want=%h", r, obs, e.val); end
        end
      end
    end
  endtask

  task automatic test_dup_wrap();
    do_reset();
    img.delete();
    img.push_back(16'h8007);
    repeat (17) img.push_back(16'h0840);
    img.push_back(16'h8001); img.push_back(16'h6030);
    img.push_back(16'h8000); img.push_back(16'h6030);
    while (img.size() < 48) img.push_back(16'h0800);
    img.push_back(16'h4030);
    load_img();
    sb.delete();
    expect_at(18, K_DSP, 16'd2);
    expect_at(18, K_T, 16'h0007);
    expect_at(20, K_PC, 16'd20);
    expect_at(20, K_T, 16'h0007);
    expect_at(22, K_PC, 16'h0030);
    expect_at(25, K_PC, 16'h0030);
    start_cpu();
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); obs = observe(e.kind); total++;
        if (obs !== e.val) begin bad++; $display("FAIL wrap_%s cyc=%0d got=%h want=%h", kname(e.kind), c, obs, e.val); end
      end
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL wrap_pending got=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_spi();
    do_reset();
    img.delete();
    img.push_back(16'h8123); img.push_back(16'h4001); img.push_back(16'hBEEF);
    load_img();
    start_cpu();
    repeat (6) @(posedge clk);
    @(negedge clk);
    nCS = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    total++; if (dut.cpu_top.pc !== 13'd0) begin bad++; $display("FAIL spi_hold_pc got=%h want=0", dut.cpu_top.pc); end
    total++; if (dut.cpu_top.dsp !== 4'd0) begin bad++; $display("FAIL spi_hold_dsp got=%h want=0", dut.cpu_top.dsp); end
    sb.delete();
    shift_word(16'h8042, 16); expect_at(0, K_IRAM0, 16'h8042);
    shift_word(16'h4001, 16); expect_at(0, K_IRAM1, 16'h4001);
    shift_word(16'h1234, 5);  expect_at(0, K_IRAM2, 16'hBEEF);
    repeat (4) @(posedge clk);
    #1;
    total++; if (dut.cpu_top.pc !== 13'd0) begin bad++; $display("FAIL spi_idle_pc got=%h want=0", dut.cpu_top.pc); end
    total++; if (dut.cpu_top.t !== 16'h0123) begin bad++; $display("FAIL spi_idle_t got=%h want=0123", dut.cpu_top.t); end
    @(negedge clk);
    nCS = 1'b1;
    expect_at(0, K_T, 16'h0042);
    expect_at(0, K_PC, 16'h0001);
    repeat (12) @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.kind); total++;
      if (obs !== e.val) begin bad++; $display("FAIL spi_%s got=%h want=%h", kname(e.kind), obs, e.val); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    img.delete();
    foreach (blink[i]) img.push_back(blink[i]);
    load_img();
    sb.delete();
    expect_at(3, K_OE, 16'h0003);
    expect_at(173, K_PINS, 16'h0001);
    start_cpu();
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); obs = observe(e.kind); total++;
        if (obs !== e.val) begin bad++; $display("FAIL mid_pre_%s cyc=%0d got=%h want=%h", kname(e.kind), c, obs, e.val); end
      end
    end
    #2;
    reset = 1'b0;
    #1;
    total++; if (dut.oe_reg !== 16'd0) begin bad++; $display("FAIL mid_async_oe got=%h want=0", dut.oe_reg); end
    total++; if (dut.out_reg !== 16'd0) begin bad++; $display("FAIL mid_async_out got=%h want=0", dut.out_reg); end
    total++; if (dut.cpu_top.pc !== 13'd0) begin bad++; $display("FAIL mid_async_pc got=%h want=0", dut.cpu_top.pc); end
    total++; if (dut.cpu_top.t !== 16'd0) begin bad++; $display("FAIL mid_async_t got=%h want=0", dut.cpu_top.t); end
    repeat (2) @(posedge clk);
    sb.delete();
    expect_at(3, K_OE, 16'h0003);
    expect_at(5, K_PC, 16'h0005);
    expect_at(172, K_PINS, 16'h0000);
    expect_at(173, K_PINS, 16'h0001);
    expect_at(344, K_PINS, 16'h0002);
    start_cpu();
    for (int c = 1; c <= 345; c++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); obs = observe(e.kind); total++;
        if (obs !== e.val) begin bad++; $display("FAIL mid_post_%s cyc=%0d got=%h want=%h", kname(e.kind), c, obs, e.val); end
      end
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL mid_pending got=%0d want=0", sb.size()); sb.delete(); end
  endtask

  initial begin
    reset = 1'b0; nCS = 1'b1; SCK = 1'b0; MOSI = 1'b0;
    test_reset();
    test_program();
    test_alu();
    test_dup_wrap();
    test_spi();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
